// File: rtl/ram_pkg.sv
// Shared types and constants for the banked RAM sequencer.
package ram_pkg;
    localparam int BANK_W     = 3;
    localparam int NUM_BANKS  = 8;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping modulo N_REQ.
import ram_pkg::*;

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PW-1:0]    idx
);
    logic found;
    int   pos;

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                idx         = PW'(pos);
            end
        end
    end
endmodule

// File: rtl/ram_bank_ctrl.sv
// Arbitrates N_REQ requesters onto the single banked-RAM port and sequences one access at a time.
//  state  | meaning
//  IDLE   | arbitrate; on a winner pulse gnt and latch its request
//  ACCESS | drive bank_en with bank/word address, we and write data
//  WAIT   | read latency countdown, bank_en low
//  DONE   | pulse done to the owner; capture mem_rdata for reads
import ram_pkg::*;

module ram_bank_ctrl #(
    parameter int N_REQ  = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       rdata,
    output logic [BANK_W-1:0]   bank_sel,
    output logic                bank_en,
    output logic [AW-4:0]       mem_addr,
    output logic                mem_we,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(RD_LAT_MAX);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     w_idx;
    logic              we_l;
    logic [AW-1:0]     addr_l;
    logic [DW-1:0]     wdata_l;
    logic [CW-1:0]     cnt;
    logic [N_REQ-1:0]  winner;
    logic [PW-1:0]     win_idx;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .idx    (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PW'(N_REQ - 1);
            w_idx     <= '0;
            we_l      <= 1'b0;
            addr_l    <= '0;
            wdata_l   <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            bank_sel  <= '0;
            bank_en   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt     <= winner;
                        w_idx   <= win_idx;
                        ptr     <= win_idx;
                        we_l    <= req_we[win_idx];
                        addr_l  <= req_addr[int'(win_idx)*AW +: AW];
                        wdata_l <= req_wdata[int'(win_idx)*DW +: DW];
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    bank_en   <= 1'b1;
                    bank_sel  <= addr_l[AW-1 -: BANK_W];
                    mem_addr  <= addr_l[AW-4:0];
                    mem_we    <= we_l;
                    mem_wdata <= wdata_l;
                    if (we_l || RD_LAT == 1) begin
                        state <= DONE;
                    end else begin
                        cnt   <= CW'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    bank_en   <= 1'b0;
                    mem_we    <= 1'b0;
                    bank_sel  <= '0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    cnt       <= cnt - CW'(1);
                    // Last count: the next edge is the one that samples mem_rdata.
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    bank_en   <= 1'b0;
                    mem_we    <= 1'b0;
                    bank_sel  <= '0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    done      <= ONE_HOT0 << w_idx;
                    if (!we_l) rdata <= mem_rdata;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Self-checking bench for ram_bank_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ram_bank_ctrl;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RL = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic [2:0]      bank_sel;
    logic            bank_en;
    logic [AW-4:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    ram_bank_ctrl #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .bank_sel  (bank_sel),
        .bank_en   (bank_en),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int model_ptr;
    logic [7:0] last_rd;

    logic [7:0] ref_mem [256];
    logic [7:0] mem [256];
    bit         mem_init_done;
    int         rd_cnt;
    logic [7:0] rd_addr;

    // Bank RAM model: data is valid only in the cycle RL after the bank_en cycle.
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] = ref_mem[i];
            mem_init_done = 1'b1;
            rd_addr = 8'h00;
        end
        if (!rst_n) rd_cnt = 0;
        else if (bank_en && mem_we) mem[{bank_sel, mem_addr}] = mem_wdata;
        else if (bank_en) begin
            rd_addr = {bank_sel, mem_addr};
            rd_cnt  = RL;
        end else if (rd_cnt > 0) rd_cnt--;
        mem_rdata = (rd_cnt == 1) ? mem[rd_addr] : ~mem[rd_addr];
    end

    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 1; k <= N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        model_ptr = N - 1;
        last_rd   = 8'h00;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'($urandom), 8'($urandom));
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, done, rdata, bank_sel, bank_en, mem_addr, mem_we, mem_wdata} !== '0)
            $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h sel=%0d en=%b addr=%h we=%b wd=%h, expected all 0",
                     gnt, done, rdata, bank_sel, bank_en, mem_addr, mem_we, mem_wdata);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b expected 0001", gnt);
        else passed++;
        req = '0;
        repeat (6) @(negedge clk);
        total++;
        if (done !== 4'b0000 || bank_en !== 1'b0) $display("FAIL reset_drain: got done=%b en=%b expected 0", done, bank_en);
        else passed++;
        model_ptr = 0;
    endtask

    task automatic test_write();
        set_req(2, 1'b1, 8'hA5, 8'h3C);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) $display("FAIL write_gnt: got %b expected 0100", gnt);
        else passed++;
        req = '0;
        @(negedge clk);
        total++;
        if ({bank_en, bank_sel, mem_addr} !== {1'b1, 3'd5, 5'h05})
            $display("FAIL write_addr: got en=%b sel=%0d addr=%h expected en=1 sel=5 addr=05", bank_en, bank_sel, mem_addr);
        else passed++;
        total++;
        if ({mem_we, mem_wdata} !== {1'b1, 8'h3C}) $display("FAIL write_data: got we=%b wd=%h expected we=1 wd=3c", mem_we, mem_wdata);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, bank_en} !== {4'b0100, 1'b0}) $display("FAIL write_done: got done=%b en=%b expected done=0100 en=0", done, bank_en);
        else passed++;
        ref_mem[8'hA5] = 8'h3C;
        total++;
        if (mem[8'hA5] !== 8'h3C) $display("FAIL write_mem: got %h expected 3c", mem[8'hA5]);
        else passed++;
        model_ptr = 2;
    endtask

    task automatic test_read();
        int be_count;
        be_count = 0;
        set_req(1, 1'b0, 8'h1F, 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) $display("FAIL read_gnt: got %b expected 0010", gnt);
        else passed++;
        req = '0;
        @(negedge clk);
        total++;
        if ({bank_en, mem_we, bank_sel, mem_addr} !== {1'b1, 1'b0, 3'd0, 5'h1F})
            $display("FAIL read_access: got en=%b we=%b sel=%0d addr=%h expected en=1 we=0 sel=0 addr=1f", bank_en, mem_we, bank_sel, mem_addr);
        else passed++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (bank_en) be_count++;
            total++;
            if (done !== 4'b0000) $display("FAIL read_early_done: got %b expected 0000", done);
            else passed++;
        end
        total++;
        if (be_count != 0) $display("FAIL read_bank_en_extra: got %0d extra pulses expected 0", be_count);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, rdata} !== {4'b0010, 8'h77}) $display("FAIL read_done: got done=%b rdata=%h expected done=0010 rdata=77", done, rdata);
        else passed++;
        model_ptr = 1;
    endtask

    task automatic test_fairness();
        logic [N-1:0] order [5];
        int ngr, nbe, viol, exp_w;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'($urandom), 8'($urandom));
        ngr = 0; nbe = 0; viol = 0;
        for (int c = 0; c < 100 && ngr < 5; c++) begin
            @(negedge clk);
            if (bank_en) nbe++;
            if ((gnt & done) != 0) viol++;
            if (gnt != 0) begin
                order[ngr] = gnt;
                ngr++;
            end
        end
        total++;
        if (ngr != 5) $display("FAIL fair_timeout: got %0d grants expected 5", ngr);
        else passed++;
        for (int k = 0; k < ngr; k++) begin
            exp_w = pick(4'b1111, model_ptr);
            model_ptr = exp_w;
            total++;
            if (order[k] !== (4'b0001 << exp_w)) $display("FAIL fair_order%0d: got %b expected %b", k, order[k], 4'b0001 << exp_w);
            else passed++;
        end
        total++;
        if (nbe != 4) $display("FAIL fair_bank_en: got %0d pulses expected 4", nbe);
        else passed++;
        total++;
        if (viol != 0) $display("FAIL fair_gnt_done_overlap: got %0d cycles expected 0", viol);
        else passed++;
        req = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_withdraw();
        int seen;
        seen = 0;
        set_req(0, 1'b0, 8'($urandom), 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) $display("FAIL withdraw_gnt0: got %b expected 0001", gnt);
        else passed++;
        req    = '0;
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt != 0) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL withdraw_no_gnt: got %0d grants expected 0", seen);
        else passed++;
        model_ptr = 0;
    endtask

    task automatic test_reset_mid_read();
        set_req(2, 1'b0, 8'($urandom), 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) $display("FAIL midrst_gnt: got %b expected 0100", gnt);
        else passed++;
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt, done, rdata, bank_sel, bank_en, mem_addr, mem_we, mem_wdata} !== '0)
            $display("FAIL midrst_outputs: got gnt=%b done=%b rdata=%h en=%b expected all 0", gnt, done, rdata, bank_en);
        else passed++;
        set_req(0, 1'b0, 8'($urandom), 8'h00);
        set_req(3, 1'b0, 8'($urandom), 8'h00);
        rst_n = 1'b1;
        model_ptr = N - 1;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) $display("FAIL midrst_restart_gnt: got %b expected 0001", gnt);
        else passed++;
        req = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic         p_we [N];
        logic [7:0]   p_a  [N];
        logic [7:0]   p_d  [N];
        int w;
        do_reset();
        pend = '0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    p_we[i] = 1'($urandom_range(0, 1));
                    p_a[i]  = 8'($urandom);
                    p_d[i]  = 8'($urandom);
                    set_req(i, p_we[i], p_a[i], p_d[i]);
                end
            end
            if (pend == 0) begin
                w = $urandom_range(0, N - 1);
                pend[w] = 1'b1;
                p_we[w] = 1'($urandom_range(0, 1));
                p_a[w]  = 8'($urandom);
                p_d[w]  = 8'($urandom);
                set_req(w, p_we[w], p_a[w], p_d[w]);
            end
            w = pick(pend, model_ptr);
            @(negedge clk);
            total++;
            if (gnt !== (4'b0001 << w)) $display("FAIL rand_gnt[%0d]: got %b expected %b", t, gnt, 4'b0001 << w);
            else passed++;
            pend[w]   = 1'b0;
            req[w]    = 1'b0;
            model_ptr = w;
            @(negedge clk);
            total++;
            if ({bank_en, bank_sel, mem_addr, mem_we, mem_wdata} !== {1'b1, p_a[w], p_we[w], p_d[w]})
                $display("FAIL rand_access[%0d]: got en=%b addr=%h we=%b wd=%h expected en=1 addr=%h we=%b wd=%h",
                         t, bank_en, {bank_sel, mem_addr}, mem_we, mem_wdata, p_a[w], p_we[w], p_d[w]);
            else passed++;
            if (p_we[w]) begin
                ref_mem[p_a[w]] = p_d[w];
                @(negedge clk);
                total++;
                if ({done, rdata} !== {4'b0001 << w, last_rd})
                    $display("FAIL rand_wdone[%0d]: got done=%b rdata=%h expected done=%b rdata=%h", t, done, rdata, 4'b0001 << w, last_rd);
                else passed++;
            end else begin
                repeat (2) @(negedge clk);
                @(negedge clk);
                last_rd = ref_mem[p_a[w]];
                total++;
                if ({done, rdata} !== {4'b0001 << w, last_rd})
                    $display("FAIL rand_rdone[%0d]: got done=%b rdata=%h expected done=%b rdata=%h", t, done, rdata, 4'b0001 << w, last_rd);
                else passed++;
            end
        end
        req = '0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_ptr = N - 1;
        last_rd   = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h1F] = 8'h77;
        repeat (2) @(negedge clk);

        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_withdraw();
        test_reset_mid_read();
        test_random();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
